// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
//   Constants shared by the fetch stage and its helpers.
//     XLEN        default address/instruction width
//     NOP_INSTR   canonical NOP (addi x0, x0, 0), loaded into IF/ID on reset/flush
//     RESET_PC    default PC loaded at reset
//     SLOT_*      encodings of the IF/ID occupancy state (EMPTY / FULL)
// -----------------------------------------------------------------------------
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // IF/ID occupancy; the FULL encoding doubles as id_valid.
    localparam logic [0:0] SLOT_EMPTY = 1'b0;
    localparam logic [0:0] SLOT_FULL  = 1'b1;

endpackage

// File: rtl/fetch_perf_cnt.sv
// -----------------------------------------------------------------------------
// fetch_perf_cnt
//   Two 32-bit saturating event counters for the fetch stage. Only built when
//   FETCH_PERF_CNT_EN is defined.
//   Ports:
//     clk             in   rising-edge clock
//     rst             in   asynchronous reset, active-high (clears both counters)
//     fetch_inc_i     in   count one committed fetch this cycle
//     stall_inc_i     in   count one backpressure stall cycle
//     perf_fetched_o  out  committed-fetch count, saturates at 32'hFFFFFFFF
//     perf_stall_o    out  stall-cycle count, saturates at 32'hFFFFFFFF
// -----------------------------------------------------------------------------
`ifdef FETCH_PERF_CNT_EN
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_inc_i,
    input  logic        stall_inc_i,
    output logic [31:0] perf_fetched_o,
    output logic [31:0] perf_stall_o
);

    logic [31:0] fetched_q, fetched_d;
    logic [31:0] stall_q,   stall_d;

    always_comb begin
        fetched_d = fetched_q;
        stall_d   = stall_q;
        if (fetch_inc_i && (fetched_q != '1)) begin
            fetched_d = fetched_q + 32'd1;
        end
        if (stall_inc_i && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_stall_o   = stall_q;

endmodule
`endif

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage. Owns the PC, presents it to a combinational
//   instruction memory and registers {pc, instr} into the IF/ID register that
//   decode drains through a valid/ready handshake. Execute may redirect the PC.
//   Build option: FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
//   Ports:
//     clk             in   rising-edge clock
//     rst             in   asynchronous reset, active-high
//     fetch_en        in   1 = fetch may advance, 0 = hold PC, no new fetch
//     imem_addr       out  byte address to instr_mem (the PC register)
//     imem_instr      in   instr_mem data for imem_addr, same cycle
//     redirect_valid  in   branch/jump taken this cycle
//     redirect_pc     in   redirect target; bits [1:0] are ignored
//     id_valid        out  IF/ID holds a valid instruction
//     id_ready        in   decode accepts IF/ID this cycle
//     id_pc           out  PC of the instruction in IF/ID
//     id_instr        out  instruction in IF/ID
//     perf_fetched    out  (FETCH_PERF_CNT_EN) committed fetches
//     perf_stall      out  (FETCH_PERF_CNT_EN) cycles stalled by decode
// -----------------------------------------------------------------------------
module fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned       XLEN       = rv_pkg::XLEN,
    parameter logic [XLEN-1:0]   START_ADDR = XLEN'(RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr
`ifdef FETCH_PERF_CNT_EN
   ,output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall
`endif
);

    localparam logic [XLEN-1:0] NOP_X      = XLEN'(NOP_INSTR);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] INSTR_STEP = XLEN'(4);

    logic [XLEN-1:0] pc_q,       pc_d;
    logic [0:0]      slot_q,     slot_d;
    logic [XLEN-1:0] id_pc_q,    id_pc_d;
    logic [XLEN-1:0] id_instr_q, id_instr_d;

    logic            full;
    logic            load;

    assign full = (slot_q == SLOT_FULL);

    // Slot is empty or is being drained this cycle, so a new fetch can land.
    assign load = fetch_en & (~full | id_ready);

    always_comb begin
        pc_d       = pc_q;
        slot_d     = slot_q;
        id_pc_d    = id_pc_q;
        id_instr_d = id_instr_q;

        if (redirect_valid) begin
            // Flush overrides everything, including a stalled slot; decode
            // still consumes the old contents if it was ready this cycle.
            pc_d       = redirect_pc & ALIGN_MASK;
            slot_d     = SLOT_EMPTY;
            id_instr_d = NOP_X;
        end else if (load) begin
            slot_d     = SLOT_FULL;
            id_pc_d    = pc_q;
            id_instr_d = imem_instr;
            pc_d       = pc_q + INSTR_STEP;
        end else if (id_ready) begin
            // Reached only with fetch_en=0: the slot drains and stays empty.
            slot_d     = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= START_ADDR;
            slot_q     <= SLOT_EMPTY;
            id_pc_q    <= '0;
            id_instr_q <= NOP_X;
        end else begin
            pc_q       <= pc_d;
            slot_q     <= slot_d;
            id_pc_q    <= id_pc_d;
            id_instr_q <= id_instr_d;
        end
    end

    assign imem_addr = pc_q;
    assign id_valid  = full;
    assign id_pc     = id_pc_q;
    assign id_instr  = id_instr_q;

`ifdef FETCH_PERF_CNT_EN
    logic perf_fetch_inc;
    logic perf_stall_inc;

    assign perf_fetch_inc = load & ~redirect_valid;
    assign perf_stall_inc = fetch_en & full & ~id_ready;

    fetch_perf_cnt u_perf (
        .clk            (clk),
        .rst            (rst),
        .fetch_inc_i    (perf_fetch_inc),
        .stall_inc_i    (perf_stall_inc),
        .perf_fetched_o (perf_fetched),
        .perf_stall_o   (perf_stall)
    );
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
`endif

    always #5 clk = ~clk;

    // Program image: 64 words, address bits [7:2] select the word.
    logic [31:0] mem [64];
    assign imem_instr = mem[imem_addr[7:2]];

    fetch_unit #(.XLEN(32), .START_ADDR(32'h0)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
`ifdef FETCH_PERF_CNT_EN
       ,.perf_fetched   (perf_fetched),
        .perf_stall     (perf_stall)
`endif
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        else passed++;
    endtask

    // ---------------- reference model ----------------
    // Observable contents of the fetch stage, updated from the rules per edge.
    logic [31:0] m_pc, m_ipc, m_instr;
    logic        m_valid;
    longint      m_fetched, m_stall;

    task automatic model_reset();
        m_pc = 32'h0; m_valid = 1'b0; m_ipc = 32'h0; m_instr = NOP;
        m_fetched = 0; m_stall = 0;
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return mem[a[7:2]];
    endfunction

    task automatic cycle();
        logic can_load;
        can_load = fetch_en && (!m_valid || id_ready);
        if (fetch_en && m_valid && !id_ready) m_stall++;
        if (redirect_valid) begin
            m_pc    = {redirect_pc[31:2], 2'b00};
            m_valid = 1'b0;
            m_instr = NOP;
        end else if (can_load) begin
            m_fetched++;
            m_ipc   = m_pc;
            m_instr = word_at(m_pc);
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end else if (id_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, {31'b0, id_valid}, {31'b0, m_valid});
        chk({tag, ".addr"}, imem_addr, m_pc);
        chk({tag, ".instr"}, id_instr, m_instr);
        if (m_valid) chk({tag, ".id_pc"}, id_pc, m_ipc);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".addr"},  imem_addr, 32'h0);
        chk({tag, ".valid"}, {31'b0, id_valid}, 32'h0);
        chk({tag, ".id_pc"}, id_pc, 32'h0);
        chk({tag, ".instr"}, id_instr, NOP);
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".pfetch"}, perf_fetched, 32'h0);
        chk({tag, ".pstall"}, perf_stall, 32'h0);
`endif
    endtask

    // Assert reset in the middle of a cycle and check it takes hold at once.
    task automatic mid_reset(input string tag);
        #3;
        rst = 1'b1;
        #1;
        check_reset({tag, ".async"});
        model_reset();
        @(posedge clk);
        #1;
        check_reset({tag, ".held"});
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        en, rdy, rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] eaddr, epc;
        int          kind;   // 0: instr unchecked, 1: mem word at epc, 2: NOP
    } vec_t;
    vec_t vt[$];

    task automatic add(input logic en, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] eaddr, input logic [31:0] epc,
                       input int kind);
        vec_t v;
        v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.eaddr = eaddr; v.epc = epc; v.kind = kind;
        vt.push_back(v);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b0;
        model_reset();
        #12;
        check_reset("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        //   en    rdy   rv    rpc            ev    addr           id_pc          kind
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0,         1); // stream
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8,         32'h4,         1);
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         1);
        add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         1); // backpressure x3
        add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         1);
        add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'hC,         32'h8,         1);
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h10,        32'hC,         1); // release
        add(1'b1, 1'b1, 1'b1, 32'h43,        1'b0, 32'h40,        32'h0,         2); // redirect, low bits dropped
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h44,        32'h40,        1);
        add(1'b1, 1'b0, 1'b1, 32'h40,        1'b0, 32'h40,        32'h0,         2); // redirect while stalled
        add(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h40,        32'h0,         2); // disabled, empty
        add(1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h44,        32'h40,        1);
        add(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h44,        32'h0,         0); // drain, pc frozen
        add(1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h44,        32'h0,         0);
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h48,        32'h44,        1); // resume at frozen pc
        add(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFC, 32'h0,         2); // redirect to top
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0,         32'hFFFF_FFFC, 1); // pc wraps
        add(1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4,         32'h0,         1);

        for (int i = 0; i < vt.size(); i++) begin
            fetch_en = vt[i].en; id_ready = vt[i].rdy;
            redirect_valid = vt[i].rv; redirect_pc = vt[i].rpc;
            cycle();
            chk($sformatf("vec%0d.valid", i), {31'b0, id_valid}, {31'b0, vt[i].ev});
            chk($sformatf("vec%0d.addr", i), imem_addr, vt[i].eaddr);
            if (vt[i].ev) chk($sformatf("vec%0d.id_pc", i), id_pc, vt[i].epc);
            if (vt[i].kind == 1) chk($sformatf("vec%0d.instr", i), id_instr, word_at(vt[i].epc));
            if (vt[i].kind == 2) chk($sformatf("vec%0d.instr", i), id_instr, NOP);
        end

        // Reset while streaming: discards the slot immediately.
        fetch_en = 1'b1; id_ready = 1'b1; redirect_valid = 1'b0;
        mid_reset("midrst");

        // 10 loads, then 3 cycles of backpressure.
        for (int i = 0; i < 10; i++) begin
            cycle();
            check_model($sformatf("load%0d", i));
        end
        id_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_model($sformatf("stall%0d", i));
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf.fetched10", perf_fetched, 32'd10);
        chk("perf.stall3",    perf_stall,   32'd3);
`endif

        // Simultaneous redirect and transfer.
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h20;
        cycle();
        check_model("redir_xfer");
        redirect_valid = 1'b0;

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            id_ready       = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 11) == 0);
            redirect_pc    = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
            if ($urandom_range(0, 149) == 0) begin
                mid_reset($sformatf("rnd%0d.rst", i));
            end else begin
                cycle();
                check_model($sformatf("rnd%0d", i));
            end
        end
`ifdef FETCH_PERF_CNT_EN
        chk("perf.fetched_end", perf_fetched, 32'(m_fetched));
        chk("perf.stall_end",   perf_stall,   32'(m_stall));
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
